serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 95 +++++++++
 tb/tb_serial_subtractor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared width default and FSM state encoding for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: the per-bit step of the serial datapath.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first, with borrow and overflow flags.
module serial_subtractor #(
    parameter int WIDTH = serial_subtractor_pkg::WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    import serial_subtractor_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             bit_d;
    logic             bit_b;

    full_subtractor u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (br),
        .d    (bit_d),
        .bout (bit_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        a_sh <= a_sh >> 1;
                        b_sh <= b_sh >> 1;
                        res  <= {bit_d, res[WIDTH-1:1]};
                        br   <= bit_b;
                        cnt  <= cnt + 1'b1;
                    end else begin
                        // Publish results only now; res is the private working copy.
                        diff  <= res;
                        bout  <= br;
                        ovf   <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // {bout, ovf, diff} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy, r;
        logic [W-1:0] d;
        logic o, bo;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r = sx - sy;
        o = (r > 127) || (r < -128);
        d = W'((int'(x) - int'(y)) & 255);
        bo = int'(x) < int'(y);
        return {bo, o, d};
    endfunction

    // Starts one operation, scrambles operands while busy, optionally injects
    // an extra start at edge k+inject, and returns on the done cycle.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input int inject, output logic [W+1:0] got,
                          output int lat, output int viol, output logic busy0);
        logic [W-1:0] prev;
        prev = diff;
        lat = -1;
        viol = 0;
        @(negedge clk);
        a = xa;
        b = xb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy0 = busy;
        for (int i = 1; i <= 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            start = (i == inject);
            if (i == inject) begin
                a = 8'h00;
                b = 8'h01;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy && done) viol++;
            if (!done && diff !== prev) viol++;
            if (done) begin
                lat = i;
                break;
            end
        end
        got = {bout, ovf, diff};
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({diff, bout, ovf, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h required 0", {diff, bout, ovf, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic directed(input string name, input logic [W-1:0] xa,
                            input logic [W-1:0] xb, input int inject,
                            input logic [W+1:0] req);
        logic [W+1:0] got;
        logic b0;
        int lat, viol;
        run_op(xa, xb, inject, got, lat, viol, b0);
        n_checks++;
        if (got !== req || got !== model(xa, xb)) begin
            n_fail++;
            $display("FAIL %s result: got %h required %h", name, got, req);
        end
        n_checks++;
        if (lat !== LAT || b0 !== 1'b1 || viol !== 0) begin
            n_fail++;
            $display("FAIL %s timing: lat %0d busy0 %b viol %0d required lat %0d busy0 1 viol 0",
                     name, lat, b0, viol, LAT);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || got !== {bout, ovf, diff}) begin
            n_fail++;
            $display("FAIL %s pulse_hold: done %b outs %h required done 0 outs %h",
                     name, done, {bout, ovf, diff}, got);
        end
    endtask

    task automatic test_directed();
        directed("sub_95_12", 8'h95, 8'h12, 0, {1'b0, 1'b0, 8'h83});
        directed("sub_12_95", 8'h12, 8'h95, 0, {1'b1, 1'b0, 8'h7D});
        directed("sub_01_ff", 8'h01, 8'hFF, 0, {1'b1, 1'b0, 8'h02});
        directed("sub_80_01", 8'h80, 8'h01, 0, {1'b0, 1'b1, 8'h7F});
        directed("sub_00_00", 8'h00, 8'h00, 0, {1'b0, 1'b0, 8'h00});
    endtask

    task automatic test_ignored_start();
        // D2 and 95 share a sign bit, so the subtraction cannot overflow.
        directed("ignored_start", 8'hD2, 8'h95, 3, {1'b0, 1'b0, 8'h3D});
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] g1, g2;
        logic b1, b2;
        int l1, l2, v1, v2;
        run_op(8'h10, 8'h01, 0, g1, l1, v1, b1);
        run_op(8'h01, 8'h02, 0, g2, l2, v2, b2);
        n_checks++;
        if (g1 !== {1'b0, 1'b0, 8'h0F} || g2 !== {1'b1, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL b2b_results: got %h %h required 00f 2ff", g1, g2);
        end
        n_checks++;
        if (l1 !== LAT || l2 !== LAT || !b2 || v1 !== 0 || v2 !== 0) begin
            n_fail++;
            $display("FAIL b2b_timing: lat %0d %0d busy %b viol %0d %0d required lat %0d",
                     l1, l2, b2, v1, v2, LAT);
        end
    endtask

    task automatic test_random();
        logic [W+1:0] got;
        logic b0;
        int lat, viol;
        logic [W-1:0] xa, xb;
        for (int t = 0; t < 20; t++) begin
            xa = W'($urandom);
            xb = W'($urandom);
            run_op(xa, xb, 0, got, lat, viol, b0);
            n_checks++;
            if (got !== model(xa, xb) || lat !== LAT || viol !== 0) begin
                n_fail++;
                $display("FAIL random_%0d: a %h b %h got %h lat %0d required %h lat %0d",
                         t, xa, xb, got, lat, model(xa, xb), LAT);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [W+1:0] got;
        logic b0;
        int lat, viol, seen;
        @(negedge clk);
        a = 8'h55;
        b = 8'h22;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({diff, bout, ovf, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_abort_outs: got %h required 0", {diff, bout, ovf, busy, done});
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_abort_quiet: active cycles %0d required 0", seen);
        end
        run_op(8'h55, 8'h22, 0, got, lat, viol, b0);
        n_checks++;
        if (got !== model(8'h55, 8'h22) || lat !== LAT) begin
            n_fail++;
            $display("FAIL reset_recover: got %h lat %0d required %h lat %0d",
                     got, lat, model(8'h55, 8'h22), LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
